// File: rtl/ga_pkg.sv
// Shared GA-stage types and defaults: scheduler state encoding, seed stride
// and the chromosome width the mutation datapath is built for.
package ga_pkg;

    localparam int          CHROM_WIDTH_DEF = 8;
    localparam logic [31:0] SEED_STEP_DEF   = 32'h9E37_79B9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEED    = 3'd1,
        WAIT_IN = 3'd2,
        MUT     = 3'd3,
        WR1     = 3'd4,
        WR2     = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/mutation_scheduler.sv
// Sequences the mutation datapath for one GA generation: reseed, accept child
// pairs, then write both mutated children to the next-population buffer.
module mutation_scheduler
    import ga_pkg::*;
#(
    parameter int          CHROM_WIDTH = CHROM_WIDTH_DEF,
    parameter int          POP_SIZE    = 16,
    parameter logic [31:0] SEED_STEP   = SEED_STEP_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [31:0]                 base_seed,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHROM_WIDTH-1:0]      in_child1,
    input  logic [CHROM_WIDTH-1:0]      in_child2,
    output logic [CHROM_WIDTH-1:0]      mut_orig_child1,
    output logic [CHROM_WIDTH-1:0]      mut_orig_child2,
    output logic [31:0]                 mut_seed,
    output logic                        mut_reset,
    input  logic [CHROM_WIDTH-1:0]      mut_child1,
    input  logic [CHROM_WIDTH-1:0]      mut_child2,
    output logic                        wr_en,
    output logic [$clog2(POP_SIZE)-1:0] wr_addr,
    output logic [CHROM_WIDTH-1:0]      wr_data,
    output logic                        busy,
    output logic                        gen_done,
    output logic [15:0]                 gen_count,
    output logic [2:0]                  fsm_state
);

    localparam int            AW        = $clog2(POP_SIZE);
    localparam int            PW        = AW - 1;
    localparam logic [PW-1:0] LAST_PAIR = PW'(POP_SIZE / 2 - 1);

    state_t                 state, state_nxt;
    logic [PW-1:0]          pair_cnt;
    logic [CHROM_WIDTH-1:0] hold;

    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEED;
            SEED:    state_nxt = WAIT_IN;
            WAIT_IN: if (in_valid) state_nxt = MUT;
            MUT:     state_nxt = WR1;
            WR1:     state_nxt = WR2;
            WR2:     state_nxt = (pair_cnt == LAST_PAIR) ? DONE : WAIT_IN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake: a pair transfers on a cycle where in_valid && in_ready; in_ready
    // is high only in WAIT_IN, so a held in_valid is consumed once per visit.
    always_comb begin
        in_ready  = (state == WAIT_IN);
        busy      = (state != IDLE);
        mut_reset = (state == IDLE) || (state == SEED);
        gen_done  = (state == DONE);
        wr_en     = (state == WR1) || (state == WR2);
        wr_addr   = '0;
        wr_data   = '0;
        if (state == WR1) begin
            wr_addr = {pair_cnt, 1'b0};
            wr_data = mut_child1;
        end else if (state == WR2) begin
            wr_addr = {pair_cnt, 1'b1};
            wr_data = hold;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mut_seed        <= '0;
            mut_orig_child1 <= '0;
            mut_orig_child2 <= '0;
            gen_count       <= '0;
            pair_cnt        <= '0;
            hold            <= '0;
        end else begin
            if (state == IDLE && start)
                mut_seed <= base_seed + {16'b0, gen_count} * SEED_STEP;
            if (state == WAIT_IN && in_valid) begin
                mut_orig_child1 <= in_child1;
                mut_orig_child2 <= in_child2;
            end
            // child2 arrives with child1 but is written a cycle later
            if (state == WR1)
                hold <= mut_child2;
            if (state == WR2 && pair_cnt != LAST_PAIR)
                pair_cnt <= pair_cnt + 1'b1;
            if (state == DONE) begin
                gen_count <= gen_count + 16'd1;
                pair_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mutation_scheduler.sv
// Bench for mutation_scheduler at POP_SIZE=4 with a registered XOR-mask
// stand-in for the mutation datapath.
module tb_mutation_scheduler;
    import ga_pkg::*;

    localparam int          CW   = 8;
    localparam int          POP  = 4;
    localparam int          AW   = 2;
    localparam logic [31:0] STEP = 32'h9E37_79B9;

    logic          clk, reset, start, in_valid, in_ready;
    logic [31:0]   base_seed, mut_seed;
    logic [CW-1:0] in_child1, in_child2, mut_orig_child1, mut_orig_child2;
    logic [CW-1:0] mut_child1, mut_child2, wr_data;
    logic          mut_reset, wr_en, busy, gen_done;
    logic [AW-1:0] wr_addr;
    logic [15:0]   gen_count;
    logic [2:0]    fsm_state;

    logic [CW-1:0]    dp_mask, dp1, dp2;
    logic [AW+CW-1:0] exp_q[$];
    logic [31:0]      model_seed;
    logic [15:0]      model_gen;
    logic             last_wr_prev;
    logic [CW-1:0]    seen [POP];
    int               n_tests, n_fail;

    mutation_scheduler #(.CHROM_WIDTH(CW), .POP_SIZE(POP), .SEED_STEP(STEP)) dut (
        .clk(clk), .reset(reset), .start(start), .base_seed(base_seed),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_child1(in_child1), .in_child2(in_child2),
        .mut_orig_child1(mut_orig_child1), .mut_orig_child2(mut_orig_child2),
        .mut_seed(mut_seed), .mut_reset(mut_reset),
        .mut_child1(mut_child1), .mut_child2(mut_child2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .gen_done(gen_done), .gen_count(gen_count),
        .fsm_state(fsm_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // datapath stand-in: one registered cycle, child-specific mask
    always @(posedge clk) begin
        dp1 <= mut_orig_child1 ^ dp_mask;
        dp2 <= mut_orig_child2 ^ {dp_mask[3:0], dp_mask[7:4]};
    end
    assign mut_child1 = dp1;
    assign mut_child2 = dp2;

    function automatic logic [CW-1:0] mut1(input logic [CW-1:0] c);
        return c ^ dp_mask;
    endfunction
    function automatic logic [CW-1:0] mut2(input logic [CW-1:0] c);
        return c ^ {dp_mask[3:0], dp_mask[7:4]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard: every write must match the next expected (addr,data);
    // gen_done must follow the write of the last address
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            logic [AW+CW-1:0] e;
            check("sb_gen_done", 32'(gen_done), 32'(last_wr_prev));
            check("sb_mut_seed", mut_seed, model_seed);
            check("sb_gen_count", 32'(gen_count), 32'(model_gen));
            if (gen_done) check("sb_q_empty_at_done", exp_q.size(), 0);
            last_wr_prev = 1'b0;
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_write", 32'(wr_en), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_wr_addr", 32'(wr_addr), 32'(e[CW +: AW]));
                    check("sb_wr_data", 32'(wr_data), 32'(e[CW-1:0]));
                    last_wr_prev = (e[CW +: AW] == AW'(POP - 1));
                end
                seen[wr_addr] = wr_data;
            end
            if (gen_done) model_gen = model_gen + 16'd1;
        end
    end

    // driver tasks
    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_gen_done", 32'(gen_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mut_reset", 32'(mut_reset), 1);
        check("rst_mut_seed", mut_seed, 0);
        check("rst_orig1", 32'(mut_orig_child1), 0);
        check("rst_orig2", 32'(mut_orig_child2), 0);
        check("rst_gen_count", 32'(gen_count), 0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
    endtask

    task automatic start_gen();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_seed = base_seed + {16'b0, model_gen} * STEP;
        @(negedge clk);
        check("seed_state", 32'(fsm_state), 32'(SEED));
        check("seed_busy", 32'(busy), 1);
        check("seed_mut_reset", 32'(mut_reset), 1);
        check("seed_in_ready", 32'(in_ready), 0);
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waited++;
            if (in_ready) break;
        end
        check("wait_ready_timeout", 32'(in_ready), 1);
    endtask

    task automatic send_pair(input int k, input logic [CW-1:0] c1, input logic [CW-1:0] c2,
                             input int delay, input logic pulse_start);
        int waited;
        wait_ready(waited);
        check("ready_latency", waited, 1);
        check("wait_mut_reset", 32'(mut_reset), 0);
        for (int i = 0; i < delay; i++) begin
            check("idle_wait_wr_en", 32'(wr_en), 0);
            check("idle_wait_state", 32'(fsm_state), 32'(WAIT_IN));
            start = pulse_start;
            @(negedge clk);
        end
        start = 1'b0;
        check("accept_state", 32'(fsm_state), 32'(WAIT_IN));
        in_valid = 1'b1;
        in_child1 = c1;
        in_child2 = c2;
        exp_q.push_back({AW'(2 * k), mut1(c1)});
        exp_q.push_back({AW'(2 * k + 1), mut2(c2)});
        @(negedge clk);
        check("mut_in_ready", 32'(in_ready), 0);
        check("mut_orig1", 32'(mut_orig_child1), 32'(c1));
        check("mut_orig2", 32'(mut_orig_child2), 32'(c2));
        in_child1 = ~c1;
        in_child2 = ~c2;
        @(negedge clk);
        check("wr1_wr_en", 32'(wr_en), 1);
        @(negedge clk);
        check("wr2_wr_en", 32'(wr_en), 1);
        check("wr2_orig1_held", 32'(mut_orig_child1), 32'(c1));
        in_valid = 1'b0;
    endtask

    task automatic end_gen();
        @(negedge clk);
        check("done_pulse", 32'(gen_done), 1);
        check("done_busy", 32'(busy), 1);
        @(negedge clk);
        check("done_gen_done_low", 32'(gen_done), 0);
        check("back_idle", 32'(fsm_state), 32'(IDLE));
        check("idle_busy", 32'(busy), 0);
        check("idle_mut_reset", 32'(mut_reset), 1);
    endtask

    initial begin
        int waited;
        n_tests = 0; n_fail = 0;
        model_seed = 0; model_gen = 0; last_wr_prev = 1'b0;
        dp_mask = 8'h00;
        reset = 1'b0;
        start = 1'bx; in_valid = 1'bx; base_seed = 'x; in_child1 = 'x; in_child2 = 'x;
        repeat (3) @(negedge clk);
        check_reset_values();
        start = 1'b0; in_valid = 1'b0; base_seed = 32'h1; in_child1 = '0; in_child2 = '0;
        #2 reset = 1'b1;

        // generation 0: identity datapath
        start_gen();
        check("g0_seed_literal", mut_seed, 32'h1);
        send_pair(0, 8'h11, 8'h22, 0, 1'b0);
        send_pair(1, 8'h33, 8'h44, 0, 1'b0);
        end_gen();
        check("g0_addr0", 32'(seen[0]), 32'h11);
        check("g0_addr1", 32'(seen[1]), 32'h22);
        check("g0_addr2", 32'(seen[2]), 32'h33);
        check("g0_addr3", 32'(seen[3]), 32'h44);
        check("g0_gen_count_literal", 32'(gen_count), 1);

        // generation 1: delayed valid with a stray start pulse
        dp_mask = 8'h0F;
        start_gen();
        check("g1_seed_literal", mut_seed, 32'h9E37_79BA);
        send_pair(0, 8'hA5, 8'h5A, 5, 1'b1);
        send_pair(1, 8'hFF, 8'h00, 0, 1'b0);
        end_gen();
        check("g1_addr0_literal", 32'(seen[0]), 32'hAA);
        check("g1_addr1_literal", 32'(seen[1]), 32'hAA);
        check("g1_gen_count_literal", 32'(gen_count), 2);

        // generation 2: reset during WR1 of the second pair
        start_gen();
        send_pair(0, 8'hC3, 8'h3C, 0, 1'b0);
        wait_ready(waited);
        in_valid = 1'b1; in_child1 = 8'h12; in_child2 = 8'h34;
        exp_q.push_back({AW'(2), mut1(8'h12)});
        exp_q.push_back({AW'(3), mut2(8'h34)});
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("g2_wr1_addr", 32'(wr_addr), 2);
        #2 reset = 1'b0;
        exp_q.delete();
        model_gen = 0; model_seed = 0; last_wr_prev = 1'b0;
        @(negedge clk);
        check_reset_values();
        #2 reset = 1'b1;

        // generation after reset restarts from scratch
        start_gen();
        check("g3_seed_literal", mut_seed, 32'h1);
        check("g3_gen_count_literal", 32'(gen_count), 0);
        send_pair(0, 8'h01, 8'h02, 0, 1'b0);
        send_pair(1, 8'h03, 8'h04, 0, 1'b0);
        end_gen();
        check("g3_addr0_literal", 32'(seen[0]), 32'h0E);
        check("g3_gen_count_after", 32'(gen_count), 1);
        check("final_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mutation_scheduler.md
# mutation_scheduler

Controller that sequences the mutation datapath for one GA generation. It accepts child pairs from crossover over a valid/ready handshake and holds them stable on the datapath inputs. It reseeds the datapath RNGs at each generation start and captures its registered outputs. It then writes both mutated children into the next-population buffer at consecutive addresses, raising `gen_done` once POP_SIZE chromosomes are written.

## Interface
- CHROM_WIDTH, 8: chromosome width; must match the mutation datapath.
- POP_SIZE, 16: chromosomes per generation; even, power of two, ≥ 4.
- SEED_STEP, 32'h9E37_79B9: per-generation seed increment.
- AW, $clog2(POP_SIZE): derived address width; not overridable.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  begin one generation; sampled only in IDLE.
- base_seed  in  32  seed for generation 0.
- in_valid  in  1  crossover pair valid.
- in_ready  out  1  controller accepts a pair this cycle.
- in_child1, in_child2  in  CHROM_WIDTH  unmutated children.
- mut_orig_child1, mut_orig_child2  out  CHROM_WIDTH  datapath inputs (registered).
- mut_seed  out  32  datapath seed.
- mut_reset  out  1  datapath RNG load, active-high.
- mut_child1, mut_child2  in  CHROM_WIDTH  datapath outputs; 1-cycle registered latency.
- wr_en  out  1  population buffer write strobe.
- wr_addr  out  AW  write address.
- wr_data  out  CHROM_WIDTH  write data.
- busy  out  1  high in every state except IDLE.
- gen_done  out  1  one-cycle pulse at end of generation.
- gen_count  out  16  completed generations; wraps 0xFFFF→0.

## Operation
- States: IDLE, SEED, WAIT_IN, MUT, WR1, WR2, DONE.
- IDLE: mut_reset=1. On start → SEED. start in any other state is ignored.
- SEED: mut_seed = base_seed + gen_count*SEED_STEP (mod 2^32). It is registered on IDLE→SEED entry and held until the next SEED. mut_reset stays 1 this cycle. Then → WAIT_IN. mut_reset=0 in WAIT_IN through DONE.
- WAIT_IN: in_ready=1. On in_valid: load in_child1/2 into mut_orig_child1/2, then → MUT. mut_orig regs hold their value until the next accept.
- MUT: one wait cycle while the datapath registers its output. → WR1.
- WR1: wr_en=1, wr_addr={pair_cnt,1'b0}, wr_data=mut_child1. Capture mut_child2 into hold reg. → WR2.
- WR2: wr_en=1, wr_addr={pair_cnt,1'b1}, wr_data=hold reg. If pair_cnt==POP_SIZE/2−1 → DONE, else pair_cnt++ and → WAIT_IN.
- DONE: gen_done=1, gen_count++, pair_cnt←0. → IDLE.
- in_ready=0 in all states except WAIT_IN; in_valid there is ignored, and no data is consumed.
- Widths: pair_cnt is AW−1 bits. Seed product truncates to 32 bits.

## Timing
- Reset values: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, gen_done=0, busy=0, mut_reset=1, mut_seed=0, mut_orig_child1/2=0, gen_count=0, pair_cnt=0, hold=0.
- start at cycle s → SEED at s+1 → first in_ready at s+2.
- Accept at cycle t → WR1 at t+2, WR2 at t+3, in_ready again at t+4. Throughput is 1 pair per 4 cycles.
- Last WR2 at cycle w → gen_done at w+1 → IDLE at w+2. start is accepted at w+2 at the earliest.
- wr_en is never high in consecutive pairs without an intervening WAIT_IN/MUT cycle.
- Reset asserted mid-generation: all registers return to reset values at once. The partial generation is discarded, and gen_count is not incremented.
- in_valid held high across WAIT_IN: accepted exactly once per WAIT_IN visit.

## Structure
- ga_pkg: state enum type, SEED_STEP default, and a shared CHROM_WIDTH default.
- No sub-module. The mutation datapath is instantiated beside this block at stage top level.

## Test plan
- Reset with all inputs X except reset=0 → every output equals its listed reset value; mut_reset=1.
- POP_SIZE=4, base_seed=0x1, start → mut_seed=0x1, mut_reset 1→0 after SEED, in_ready at s+2.
- POP_SIZE=4, datapath with MUT_RATE=0, pairs (0x11,0x22),(0x33,0x44) → writes addr0..3 = 0x11,0x22,0x33,0x44; gen_done one cycle; gen_count=1.
- Second generation → mut_seed=0x1+0x9E3779B9=0x9E3779BA.
- in_valid delayed 5 cycles in WAIT_IN → no wr_en and state stable; accept when valid rises; start pulsed mid-generation has no effect.
- reset dropped during WR1 of pair 1 → next generation restarts at addr 0 with gen_count=0 and mut_seed=base_seed.
